// File: rtl/mux_rr_arb_if.sv
// Handshake bundle between N producers, the arbitrating mux and one consumer.
// The slave modport is the arbiter's view; master is the producers/consumer side.
interface mux_rr_arb_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int IDXW = $clog2(CHANNELS);

    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    logic [IDXW-1:0]           out_chan;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_chan
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_chan
    );
endinterface

// File: rtl/mux_rr_arb.sv
// N-channel arbitrating multiplexer with a one-deep registered output tagged by
// the winning channel; round-robin or fixed-priority grant selected by RR_MODE.
module mux_rr_arb #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int RR_MODE  = 1,
    parameter int IDXW     = $clog2(CHANNELS)
) (
    input logic                clk,
    input logic                rst_n,
    mux_rr_arb_if.slave        bus
);

    logic [IDXW-1:0]     ptr;
    logic [CHANNELS-1:0] grant;
    logic [IDXW-1:0]     gidx;
    logic [WIDTH-1:0]    sel_data;
    logic                found;
    logic                load_en;
    logic                xfer;
    int                  idx;

    assign load_en = !bus.out_valid || bus.out_ready;

    // Scan from the pointer (or from 0 in fixed-priority mode) and take the first requester.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = (RR_MODE != 0) ? ((int'(ptr) + k) % CHANNELS) : k;
            if (!found && bus.in_valid[IDXW'(idx)]) begin
                found                = 1'b1;
                grant[IDXW'(idx)]    = 1'b1;
                gidx                 = IDXW'(idx);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                sel_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Reset gating keeps every producer stalled while the block is held in reset.
    assign bus.in_ready = rst_n ? (grant & {CHANNELS{load_en}}) : '0;
    assign xfer         = |bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_chan  <= '0;
            ptr           <= '0;
        end else if (load_en) begin
            if (xfer) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= sel_data;
                bus.out_chan  <= gidx;
                ptr           <= (gidx == IDXW'(CHANNELS-1)) ? '0 : gidx + 1'b1;
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end

    a_onehot_ready: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.in_ready));

    a_stall_no_ready: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready) |-> (bus.in_ready == '0));

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready) |=>
            (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_chan)));

endmodule

// File: tb/tb_mux_rr_arb.sv
// Scoreboard bench: three DUT configurations (4ch RR, 4ch fixed priority, 3ch RR)
// driven by directed vectors; per-DUT monitors pop expected words on each accepted output.
module tb_mux_rr_arb;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    int qa[$];
    int qb[$];
    int qc[$];

    mux_rr_arb_if #(.WIDTH(8), .CHANNELS(4)) busa();
    mux_rr_arb_if #(.WIDTH(8), .CHANNELS(4)) busb();
    mux_rr_arb_if #(.WIDTH(8), .CHANNELS(3)) busc();

    mux_rr_arb #(.WIDTH(8), .CHANNELS(4), .RR_MODE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(busa));
    mux_rr_arb #(.WIDTH(8), .CHANNELS(4), .RR_MODE(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(busb));
    mux_rr_arb #(.WIDTH(8), .CHANNELS(3), .RR_MODE(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(busc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ex(input int chan, input int data);
        return chan * 256 + data;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int which, input logic [3:0] valid, input logic ready);
        case (which)
            0: begin busa.in_valid = valid;      busa.out_ready = ready; end
            1: begin busb.in_valid = valid;      busb.out_ready = ready; end
            default: begin busc.in_valid = valid[2:0]; busc.out_ready = ready; end
        endcase
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Each monitor consumes one expected word per accepted output beat.
    always @(negedge clk) begin
        if (rst_n && busa.out_valid && busa.out_ready) begin
            if (qa.size() == 0) checkOutput("a_unexpected_word", 1, 0);
            else checkOutput("a_word", int'(busa.out_chan) * 256 + int'(busa.out_data), qa.pop_front());
        end
        if (rst_n && busb.out_valid && busb.out_ready) begin
            if (qb.size() == 0) checkOutput("b_unexpected_word", 1, 0);
            else checkOutput("b_word", int'(busb.out_chan) * 256 + int'(busb.out_data), qb.pop_front());
        end
        if (rst_n && busc.out_valid && busc.out_ready) begin
            if (qc.size() == 0) checkOutput("c_unexpected_word", 1, 0);
            else checkOutput("c_word", int'(busc.out_chan) * 256 + int'(busc.out_data), qc.pop_front());
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        busa.in_data = {8'd4, 8'd3, 8'd2, 8'd1};
        busb.in_data = {8'd4, 8'd3, 8'd2, 8'd1};
        busc.in_data = {8'd3, 8'd2, 8'd1};
        applyStimulus(0, 4'b1111, 1'b1);
        applyStimulus(1, 4'b1111, 1'b1);
        applyStimulus(2, 4'b0111, 1'b1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_a_out_valid", int'(busa.out_valid), 0);
        checkOutput("rst_a_out_data",  int'(busa.out_data), 0);
        checkOutput("rst_a_out_chan",  int'(busa.out_chan), 0);
        checkOutput("rst_a_in_ready",  int'(busa.in_ready), 0);
        checkOutput("rst_b_in_ready",  int'(busb.in_ready), 0);
        checkOutput("rst_c_out_valid", int'(busc.out_valid), 0);
        checkOutput("rst_c_in_ready",  int'(busc.in_ready), 0);

        nextCycle();
        rst_n = 1'b1;

        fork
            begin
                applyStimulus(0, 4'b1111, 1'b1);
                @(negedge clk);
                checkOutput("a_first_grant", int'(busa.in_ready), 4'b0001);
                for (int i = 0; i < 11; i++) begin
                    qa.push_back(ex(i % 4, i % 4 + 1));
                    nextCycle();
                end
                // Pointer now at 3: sparse requests on 0 and 2 must wrap to 0 first.
                applyStimulus(0, 4'b0101, 1'b1);
                qa.push_back(ex(0, 1));
                qa.push_back(ex(2, 3));
                qa.push_back(ex(0, 1));
                repeat (3) nextCycle();
                applyStimulus(0, 4'b1111, 1'b1);
                qa.push_back(ex(1, 2));
                nextCycle();
                applyStimulus(0, 4'b1111, 1'b0);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    checkOutput("a_bp_out_valid", int'(busa.out_valid), 1);
                    checkOutput("a_bp_out_data",  int'(busa.out_data), 2);
                    checkOutput("a_bp_in_ready",  int'(busa.in_ready), 0);
                    nextCycle();
                end
                applyStimulus(0, 4'b1111, 1'b1);
                qa.push_back(ex(2, 3));
                @(negedge clk);
                checkOutput("a_release_in_ready", int'(busa.in_ready), 4'b0100);
                nextCycle();
                applyStimulus(0, 4'b0000, 1'b1);
                nextCycle();
                @(negedge clk);
                checkOutput("a_idle_out_valid", int'(busa.out_valid), 0);
            end
            begin
                applyStimulus(1, 4'b1110, 1'b1);
                @(negedge clk);
                checkOutput("b_first_grant", int'(busb.in_ready), 4'b0010);
                for (int i = 0; i < 4; i++) begin
                    qb.push_back(ex(1, 2));
                    nextCycle();
                end
                applyStimulus(1, 4'b1100, 1'b1);
                @(negedge clk);
                checkOutput("b_drop1_in_ready", int'(busb.in_ready), 4'b0100);
                for (int i = 0; i < 3; i++) begin
                    qb.push_back(ex(2, 3));
                    nextCycle();
                end
                applyStimulus(1, 4'b0000, 1'b1);
                nextCycle();
                @(negedge clk);
                checkOutput("b_idle_out_valid", int'(busb.out_valid), 0);
            end
            begin
                applyStimulus(2, 4'b0111, 1'b1);
                @(negedge clk);
                checkOutput("c_first_grant", int'(busc.in_ready), 3'b001);
                for (int i = 0; i < 5; i++) begin
                    qc.push_back(ex(i % 3, i % 3 + 1));
                    nextCycle();
                end
                applyStimulus(2, 4'b0000, 1'b1);
                nextCycle();
                @(negedge clk);
                checkOutput("c_idle_out_valid", int'(busc.out_valid), 0);
            end
        join

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("a_queue_drained", qa.size(), 0);
        checkOutput("b_queue_drained", qb.size(), 0);
        checkOutput("c_queue_drained", qc.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
